// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment result display: pin idle levels,
// the active-low hex glyph table and the default timing parameters.
package seg7_pkg;

    localparam int REFRESH_DIV_DEFAULT   = 100000;
    localparam int STABLE_CYCLES_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Glyphs are {g,f,e,d,c,b,a}, active-low, indexed by hex digit value.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_code
);

    assign seg_code = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/result_display.sv
// Filters store transients on the DMEM result word and scans the settled
// value as hex across a 4-digit common-anode seven-segment display.
module result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = REFRESH_DIV_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [15:0]      cand;
    logic [15:0]      shown;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [1:0]       dig;
    logic [3:0]       nibble;
    logic [6:0]       seg_code;
    logic             upper_zero;
    logic             digit_blank;

    // A value reaches shown only after matching cand for STABLE_CYCLES edges;
    // any difference restarts the count and leaves the old shown in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand  <= '0;
            cnt   <= '0;
            shown <= '0;
        end else if (result != cand) begin
            cand <= result;
            cnt  <= '0;
        end else if (cnt < CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            shown <= cand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            dig <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            dig <= dig + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Digit 0 is never blanked so that a zero value still reads "0".
    always_comb begin
        nibble     = shown[{dig, 2'b00} +: 4];
        upper_zero = 1'b0;
        case (dig)
            2'd1:    upper_zero = (shown[15:4]  == 12'h000);
            2'd2:    upper_zero = (shown[15:8]  == 8'h00);
            2'd3:    upper_zero = (shown[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
        digit_blank = blank_lz && upper_zero;
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble   (nibble),
        .seg_code (seg_code)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (digit_blank) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << dig);
            seg <= seg_code;
        end
    end

endmodule

// File: doc/result_display.md
# result_display

Reader-side consumer of the SoC's memory-mapped 16-bit `result` output, which the CPU writes through DMEM. It filters store transients, then time-multiplexes the settled value onto a 4-digit common-anode seven-segment display as hex. It sits beside `dmem_inst` in the board top, in the `clk_cpu` domain.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit. Must be ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive cycles `result` must hold before it is displayed. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock, the CPU clock `clk_cpu`.
- `reset`  in  1  asynchronous, active-low reset.
- `result`  in  16  value to display, unregistered from DMEM.
- `blank_lz`  in  1  1 = blank leading-zero digits.
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low.

## Operation
**Stability filter.** Registers `cand[15:0]`, `cnt`, `shown[15:0]`. On each edge:
- `result != cand`: load `cand <= result` and `cnt <= 0`.
- `result == cand` and `cnt < STABLE_CYCLES-1`: increment `cnt`.
- `result == cand` and `cnt == STABLE_CYCLES-1`: `shown <= cand`. `cnt` saturates.
- The value in `shown` is never a value that held for fewer than `STABLE_CYCLES` cycles.

**Scanner.**
- Divider `div` counts 0..`REFRESH_DIV-1`. When it wraps to 0, the digit index `dig` advances 0→1→2→3→0.
- Digit `i` displays `shown[4i+3:4i]`.

**Decode, active-low, hex `0`..`F`:** 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.

**Blanking.**
- With `blank_lz=1`, digit `i>0` is blanked when every nibble `i..3` of `shown` is zero.
- Digit 0 is never blanked, so a zero value shows "0".
- A blanked digit drives `an` all ones and `seg = 7'h7F`.
- `blank_lz` is sampled with `shown` on the same cycle; it is not filtered.

**Outputs.**
- Drive registers: `an <= ~(4'b1 << dig)` unless the digit is blanked, and `seg <= decode(nibble)`.
- Both outputs come from registers; there is no combinational path from `result` to the pins.

## Timing
- Reset asserted, asynchronously: `an = 4'hF`, `seg = 7'h7F`, `cand = shown = 0`, `cnt = 0`, `div = 0`, `dig = 0`.
- First edge after release: `an = 4'b1110`, `seg = 7'h40`, showing `shown = 0`.
- Filter latency: a new value is first sampled into `cand` at edge k. If it is held, `shown` loads at edge k+`STABLE_CYCLES`. The pins reflect it one edge later, on whichever digit is currently active.
- Any change of `result` before `shown` loads restarts the count; the previous `shown` is kept.
- Digit period is exactly `REFRESH_DIV` cycles; the full frame is 4×`REFRESH_DIV`.
- `an`/`seg` change on the edge after `dig` changes, together as one register update, so both move on the same edge.
- `shown` changing mid-digit updates `seg` on the next edge. No frame alignment is applied.
- Reset mid-scan: outputs go to the off state immediately, and scanning restarts at digit 0.
- Simultaneous divider wrap and `shown` load: the new digit shows the new value.

## Structure
- Package `seg7_pkg` holds:
  - constants `SEG_BLANK = 7'h7F` and `AN_OFF = 4'hF`;
  - the 16-entry hex-to-segment table;
  - the default values of `REFRESH_DIV` and `STABLE_CYCLES`.
- Sub-module `hex_to_seg7`: combinational 4-bit→7-bit decode, instantiated once on the muxed nibble.
- Stability filter, divider, and blanking logic live in `result_display`.

## Test plan
Directed scenarios; benches run with `REFRESH_DIV=4`, `STABLE_CYCLES=4`.
- **Reset:** hold `reset=0` → `an=F`, `seg=7F`. Release with `result=0` → `an` cycles 1110, 1101, 1011, 0111, each for 4 cycles, with `seg=40` on every digit.
- **Decode:** set `result=16'h12AF` and hold → after ≤5 edges, `shown=12AF`. Digits 0..3 show `seg` 0E, 08, 24, 79.
- **Glitch rejection:** apply 0x1234 for 2 cycles, then 0x5678 held → `shown` goes 0000→5678 and never 1234. The load happens exactly 4 edges after 5678 is first sampled.
- **Leading-zero blanking:** `blank_lz=1`, `result=16'h0050` → `an[3]` and `an[2]` stay 1, digit 1 shows `seg=12`, digit 0 shows `seg=40`. With `result=0`, only digit 0 lights and shows 40.
- **Async reset mid-scan:** assert `reset` during digit 2 → outputs go off the same timestep. After release, scanning restarts at digit 0 and `shown=0`.
- **Wrap with simultaneous load:** time a new stable value to land on the digit 3→0 wrap edge → digit 0 displays the new nibble with no stale-value cycle.
